// File: rtl/divider_rv_seq.sv
// divider_rv_seq: sequential RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle, valid/ready on both sides.
// Optional DIV_EARLY_OUT_EN: requests with |dividend| < |divisor| complete in DONE directly after capture.
module divider_rv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic [4:0]  i_tag,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic [4:0]  o_tag
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  tag_q, tag_d;
    logic [31:0] dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d, quo_q, quo_d, res_q, res_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        negq_q, negq_d, negr_q, negr_d;
    logic        sgn, a_neg, b_neg, div0, ovf, ge;
    logic [31:0] abs_a, abs_b, special, rem_sh, rem_n, quo_n, q_fin, r_fin;

    assign sgn     = ~i_op[0];
    assign a_neg   = sgn & i_dividend[31];
    assign b_neg   = sgn & i_divisor[31];
    assign abs_a   = a_neg ? -i_dividend : i_dividend;
    assign abs_b   = b_neg ? -i_divisor : i_divisor;
    assign div0    = i_divisor == 32'd0;
    assign ovf     = sgn && i_dividend == 32'h8000_0000 && i_divisor == 32'hFFFF_FFFF;
    assign special = div0 ? (i_op[1] ? i_dividend : 32'hFFFF_FFFF) : (i_op[1] ? 32'd0 : 32'h8000_0000);
    // Restoring step: remainder stays below the divisor, so 32 bits suffice.
    assign rem_sh  = {rem_q[30:0], dvd_q[31]};
    assign ge      = rem_sh >= dsr_q;
    assign rem_n   = ge ? rem_sh - dsr_q : rem_sh;
    assign quo_n   = {quo_q[30:0], ge};
    assign q_fin   = negq_q ? -quo_n : quo_n;
    assign r_fin   = negr_q ? -rem_n : rem_n;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            IDLE: if (i_valid) begin
                op_d   = i_op;
                tag_d  = i_tag;
                dvd_d  = abs_a;
                dsr_d  = abs_b;
                rem_d  = 32'd0;
                quo_d  = 32'd0;
                cnt_d  = 6'd0;
                negq_d = a_neg ^ b_neg;
                negr_d = a_neg;
                if (div0 || ovf) begin
                    res_d   = special;
                    state_d = DONE;
                end
`ifdef DIV_EARLY_OUT_EN
                else if (abs_a < abs_b) begin
                    res_d   = i_op[1] ? i_dividend : 32'd0;
                    state_d = DONE;
                end
`endif
                else state_d = BUSY;
            end
            BUSY: begin
                rem_d = rem_n;
                quo_d = quo_n;
                dvd_d = {dvd_q[30:0], 1'b0};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    res_d   = op_q[1] ? r_fin : q_fin;
                    state_d = DONE;
                end
            end
            DONE: if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 2'd0;
            tag_q   <= 5'd0;
            dvd_q   <= 32'd0;
            dsr_q   <= 32'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            res_q   <= 32'd0;
            cnt_q   <= 6'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign o_ready  = state_q == IDLE;
    assign o_valid  = state_q == DONE;
    assign o_result = res_q;
    assign o_tag    = tag_q;
endmodule

// File: tb/tb_divider_rv_seq.sv
// tb_divider_rv_seq: directed vectors for divider_rv_seq checked against an arithmetic reference model.
module tb_divider_rv_seq;
    logic        clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
    logic [1:0]  i_op = 2'd0;
    logic [31:0] i_dividend = 32'd0, i_divisor = 32'd0;
    logic [4:0]  i_tag = 5'd0;
    logic        o_ready, o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_tag;
    logic [31:0] exp_res = 32'd0;
    logic [4:0]  exp_tag = 5'd0;
    int          checks = 0, failures = 0;

    divider_rv_seq dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .i_tag(i_tag), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_tag(o_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        if (op[0]) return op[1] ? a % b : a / b;
        return op[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    endfunction

    // Edges after the accept edge until o_valid is seen high.
    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa, ab;
        if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
        aa = (!op[0] && a[31]) ? -a : a;
        ab = (!op[0] && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
        if (aa < ab) return 0;
`endif
        return 32;
    endfunction

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            chk("model_result", o_result, exp_res);
            chk("model_tag", {27'd0, o_tag}, {27'd0, exp_tag});
            chk("ready_low_in_done", {31'd0, o_ready}, 32'd0);
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] hand, input int hold, input bit inject);
        int n;
        logic [31:0] held;
        @(negedge clk);
        chk("ready_before_req", {31'd0, o_ready}, 32'd1);
        i_op = op; i_dividend = a; i_divisor = b; i_tag = tag; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk);
        exp_res = model(op, a, b);
        exp_tag = tag;
        #1 i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 100) begin
            if (inject && n == 5) begin
                i_op = 2'd1; i_dividend = 32'd1; i_divisor = 32'd1; i_tag = 5'd31; i_valid = 1'b1;
            end
            if (n == 6) i_valid = 1'b0;
            @(posedge clk);
            #1 n++;
        end
        i_valid = 1'b0;
        chk("latency", n, model_lat(op, a, b));
        chk("hand_result", o_result, hand);
        held = o_result;
        for (int k = 0; k < hold; k++) begin
            if (inject && k == 1) begin
                i_op = 2'd1; i_dividend = 32'd1; i_divisor = 32'd1; i_tag = 5'd31; i_valid = 1'b1;
            end
            @(posedge clk);
            #1 i_valid = 1'b0;
            chk("hold_valid", {31'd0, o_valid}, 32'd1);
            chk("hold_result", o_result, held);
            chk("hold_tag", {27'd0, o_tag}, {27'd0, tag});
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        chk("pop_valid", {31'd0, o_valid}, 32'd0);
        chk("pop_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1 chk("idle_after_pop", {30'd0, o_valid, o_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_tag", {27'd0, o_tag}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op(2'b01, 32'd100, 32'd7, 5'd3, 32'd14, 0, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 5'd4, 32'd2, 0, 1'b0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 0, 1'b0);
        do_op(2'b01, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, 0, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 0, 1'b0);
        do_op(2'b01, 32'd1000, 32'd10, 5'd12, 32'd100, 5, 1'b1);
        do_op(2'b00, 32'd9, 32'd0, 5'd13, 32'hFFFF_FFFF, 5, 1'b1);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd14, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(2'b01, 32'd3, 32'd10, 5'd15, 32'd0, 0, 1'b0);
        do_op(2'b11, 32'd3, 32'd10, 5'd16, 32'd3, 0, 1'b0);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd10, 5'd17, 32'd0, 0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFD, 32'd10, 5'd18, 32'hFFFF_FFFD, 0, 1'b0);
        @(negedge clk);
        i_op = 2'b01; i_dividend = 32'hFFFF_FFFF; i_divisor = 32'd3; i_tag = 5'd20; i_valid = 1'b1;
        @(posedge clk);
        #1 i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_ready", {31'd0, o_ready}, 32'd1);
        chk("abort_result", o_result, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        do_op(2'b01, 32'd9, 32'd3, 5'd21, 32'd3, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
